// File: rtl/test_module_sync_pkg.sv
// Shared types and sizing helpers for the test_module_sync input conditioner.
package test_module_sync_pkg;

  typedef struct packed {
    logic rise;
    logic fall;
  } strobe_t;

  // Counter must hold values 0..db, so db+1 distinct codes.
  function automatic int cnt_width(input int db);
    return (db < 1) ? 1 : $clog2(db + 1);
  endfunction

endpackage

// File: rtl/test_module_sync_bit_sync.sv
// Plain multi-flop synchroniser for one asynchronous level; no logic between stages.
module bit_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] stage_q;
  logic [SYNC_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/test_module_sync.sv
// Synchronise and debounce a raw test bit; registered level plus one-cycle
// rise/fall strobes on each accepted change.
module test_module_sync
  import test_module_sync_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic test_input,
  output logic test_output,
  output logic test_rise,
  output logic test_fall
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W:0]  DB_LIMIT = (CNT_W + 1)'(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("test_module_sync: need SYNC_STAGES>=2 and DEBOUNCE_CYCLES>=1");
  end

  logic synced;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_bit_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (test_input),
    .dout (synced)
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  strobe_t          strb_q, strb_d;
  logic [CNT_W:0]   cnt_inc;
  logic             mismatch;
  logic             accept;

  // Counter clears on a match or on acceptance, so it never reaches DB_LIMIT.
  always_comb begin
    cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    mismatch = (synced != out_q);
    accept   = mismatch && (cnt_inc == DB_LIMIT);
    cnt_d    = '0;
    out_d    = out_q;
    strb_d   = '0;
    if (accept) begin
      out_d       = synced;
      strb_d.rise = synced;
      strb_d.fall = ~synced;
    end else if (mismatch) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      out_q  <= RESET_VALUE;
      strb_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      strb_q <= strb_d;
    end
  end

  assign test_output = out_q;
  assign test_rise   = strb_q.rise;
  assign test_fall   = strb_q.fall;

endmodule

// File: tb/tb_test_module_sync.sv
// Self-checking bench for test_module_sync: segment table plus per-edge scoreboard.
module tb_test_module_sync;

  localparam int S  = 2;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst;
  logic test_input;
  logic test_output;
  logic test_rise;
  logic test_fall;

  always #5 clk = ~clk;

  test_module_sync #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (DB),
    .RESET_VALUE     (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .test_input  (test_input),
    .test_output (test_output),
    .test_rise   (test_rise),
    .test_fall   (test_fall)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural reference: delay line for sync, window test for debounce.
  logic m_sd   [0:S-1];
  logic m_hist [0:DB-1];
  logic m_out, m_rise, m_fall;

  logic [2:0] sb[$];

  int seg_rise, seg_fall;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic d);
    logic all_diff;
    if (r) begin
      for (int i = 0; i < S; i++)  m_sd[i]   = 1'b0;
      for (int i = 0; i < DB; i++) m_hist[i] = 1'b0;
      m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++) if (m_hist[i] == m_out) all_diff = 1'b0;
      if (all_diff) begin
        m_out  = ~m_out;
        m_rise = m_out;
        m_fall = ~m_out;
      end else begin
        m_rise = 1'b0;
        m_fall = 1'b0;
      end
      for (int i = S - 1; i > 0; i--) m_sd[i] = m_sd[i-1];
      m_sd[0] = d;
      for (int i = 0; i < DB - 1; i++) m_hist[i] = m_hist[i+1];
      m_hist[DB-1] = m_sd[S-1];
    end
  endtask

  task automatic step(input logic r, input logic d);
    logic [2:0] exp;
    @(negedge clk);
    rst        = r;
    test_input = d;
    model_edge(r, d);
    sb.push_back({m_out, m_rise, m_fall});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      exp = sb.pop_front();
      chk("edge_out_rise_fall", int'({test_output, test_rise, test_fall}), int'(exp));
    end
    if (test_rise) seg_rise++;
    if (test_fall) seg_fall++;
  endtask

  typedef struct {
    string name;
    logic  r;
    logic  d;
    int    ncyc;
    logic  exp_out;
    int    exp_rise;
    int    exp_fall;
  } seg_t;

  seg_t segs[$];

  task automatic run_seg(input seg_t s);
    seg_rise = 0;
    seg_fall = 0;
    for (int i = 0; i < s.ncyc; i++) step(s.r, s.d);
    chk({s.name, "_out"},  int'(test_output), int'(s.exp_out));
    chk({s.name, "_rise"}, seg_rise, s.exp_rise);
    chk({s.name, "_fall"}, seg_fall, s.exp_fall);
  endtask

  initial begin
    rst        = 1'b1;
    test_input = 1'b1;

    segs.push_back('{"reset_hold",     1'b1, 1'b1, 3, 1'b0, 0, 0});
    segs.push_back('{"rise_wait5",     1'b0, 1'b1, 5, 1'b0, 0, 0});
    segs.push_back('{"rise_edge6",     1'b0, 1'b1, 1, 1'b1, 1, 0});
    segs.push_back('{"rise_hold",      1'b0, 1'b1, 4, 1'b1, 0, 0});
    segs.push_back('{"fall_wait5",     1'b0, 1'b0, 5, 1'b1, 0, 0});
    segs.push_back('{"fall_edge6",     1'b0, 1'b0, 1, 1'b0, 0, 1});
    segs.push_back('{"fall_hold",      1'b0, 1'b0, 6, 1'b0, 0, 0});
    segs.push_back('{"pulse1_hi",      1'b0, 1'b1, 1, 1'b0, 0, 0});
    segs.push_back('{"pulse1_lo",      1'b0, 1'b0, 8, 1'b0, 0, 0});
    segs.push_back('{"pulse3_hi",      1'b0, 1'b1, 3, 1'b0, 0, 0});
    segs.push_back('{"pulse3_lo",      1'b0, 1'b0, 8, 1'b0, 0, 0});
    segs.push_back('{"rst_mid_pre",    1'b0, 1'b1, 5, 1'b0, 0, 0});
    segs.push_back('{"rst_mid_pulse",  1'b1, 1'b1, 1, 1'b0, 0, 0});
    segs.push_back('{"rst_mid_wait5",  1'b0, 1'b1, 5, 1'b0, 0, 0});
    segs.push_back('{"rst_mid_accept", 1'b0, 1'b1, 1, 1'b1, 1, 0});
    segs.push_back('{"back_to_zero",   1'b0, 1'b0, 8, 1'b0, 0, 1});

    foreach (segs[k]) run_seg(segs[k]);

    // Toggle every 5 cycles for 100 cycles, then settle.
    seg_rise = 0;
    seg_fall = 0;
    for (int t = 0; t < 20; t++) begin
      for (int c = 0; c < 5; c++) step(1'b0, (t % 2 == 0) ? 1'b1 : 1'b0);
    end
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
    chk("toggle_rise_count", seg_rise, 10);
    chk("toggle_fall_count", seg_fall, 10);
    chk("toggle_final_out",  int'(test_output), 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
